// File: rtl/capture_buffer_n.sv
// N-channel triggered capture buffer: circular per-channel sample store with a
// pre-trigger window, edge/auto/single-shot triggering and a frozen frame that
// the display reads by screen X position.
module capture_buffer_n #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned PRETRIG      = 256,
  parameter int unsigned AUTO_TIMEOUT = 4096,
  localparam int unsigned DEPTH       = 2 ** ADDR_W,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     sample_en_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [CH_W-1:0]          trig_ch_i,
  input  logic [DATA_W-1:0]        trig_level_i,
  input  logic                     trig_falling_i,
  input  logic [1:0]               mode_i,
  input  logic                     arm_i,
  input  logic                     hold_i,
  input  logic                     frame_tick_i,
  input  logic [ADDR_W-1:0]        rd_x_i,
  input  logic [CH_W-1:0]          rd_ch_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     triggered_o,
  output logic                     auto_fired_o,
  output logic                     frame_ready_o,
  output logic                     frame_valid_o
);

  localparam int unsigned CNT_MAX = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FillLast = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0] AutoLast = CNT_W'(AUTO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PostLast = CNT_W'(DEPTH - PRETRIG - 2);

  localparam logic [1:0] ModeAuto   = 2'b01;
  localparam logic [1:0] ModeSingle = 2'b10;

  typedef enum logic [2:0] {StIdle, StFill, StArmed, StPost, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   prev_trig_q, prev_trig_d;
  logic                prev_valid_q, prev_valid_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [1:0]          mode_q, mode_d;
  logic                triggered_q, triggered_d;
  logic                auto_fired_q, auto_fired_d;
  logic                frame_ready_q, frame_ready_d;
  logic                frame_valid_q, frame_valid_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   mem_q [NUM_CH][DEPTH];
  logic [DATA_W-1:0]   cur_trig;
  logic                hit;
  logic                we;
  logic                go_fill;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CH_W-1:0]     rd_ch_sel;

  // Select the trigger-source sample; out-of-range channel falls back to 0.
  always_comb begin
    cur_trig = ch_data_i[DATA_W-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (trig_ch_i == CH_W'(c)) cur_trig = ch_data_i[c*DATA_W +: DATA_W];
    end
  end

  // Edge detect against the previous trigger-channel sample.
  always_comb begin
    if (trig_falling_i) begin
      hit = prev_valid_q && (prev_trig_q >= trig_level_i) && (cur_trig < trig_level_i);
    end else begin
      hit = prev_valid_q && (prev_trig_q < trig_level_i) && (cur_trig >= trig_level_i);
    end
  end

  assign we        = sample_en_i &&
                     (state_q == StFill || state_q == StArmed || state_q == StPost);
  assign rd_addr   = trig_addr_q - ADDR_W'(PRETRIG) + rd_x_i;
  assign rd_ch_sel = (32'(rd_ch_i) < NUM_CH) ? rd_ch_i : '0;

  // Capture FSM next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    prev_trig_d   = prev_trig_q;
    prev_valid_d  = prev_valid_q;
    trig_addr_d   = trig_addr_q;
    mode_d        = mode_q;
    triggered_d   = triggered_q;
    auto_fired_d  = auto_fired_q;
    frame_ready_d = 1'b0;
    frame_valid_d = frame_valid_q;
    go_fill       = 1'b0;

    if (we) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      prev_trig_d = cur_trig;
    end

    case (state_q)
      StIdle: go_fill = (mode_i != ModeSingle) || arm_i;
      StFill: begin
        if (sample_en_i) begin
          if (cnt_q == FillLast) begin
            state_d      = StArmed;
            cnt_d        = '0;
            // The first ARMED sample only primes prev_trig.
            prev_valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StArmed: begin
        if (sample_en_i) begin
          prev_valid_d = 1'b1;
          if (hit) begin
            state_d     = StPost;
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
          end else if (mode_q == ModeAuto && cnt_q == AutoLast) begin
            state_d      = StPost;
            trig_addr_d  = wr_ptr_q;
            triggered_d  = 1'b1;
            auto_fired_d = 1'b1;
            cnt_d        = '0;
          end else if (cnt_q != AutoLast) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPost: begin
        if (sample_en_i) begin
          if (cnt_q == PostLast) begin
            state_d       = StDone;
            frame_ready_d = 1'b1;
            frame_valid_d = 1'b1;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (!hold_i) go_fill = (mode_q == ModeSingle) ? arm_i : frame_tick_i;
      end
      default: state_d = StIdle;
    endcase

    if (go_fill) begin
      state_d       = StFill;
      cnt_d         = '0;
      triggered_d   = 1'b0;
      auto_fired_d  = 1'b0;
      frame_valid_d = 1'b0;
      mode_d        = mode_i;
    end
  end

  // State, control registers and the registered read port.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      prev_trig_q   <= '0;
      prev_valid_q  <= 1'b0;
      trig_addr_q   <= '0;
      mode_q        <= '0;
      triggered_q   <= 1'b0;
      auto_fired_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      prev_trig_q   <= prev_trig_d;
      prev_valid_q  <= prev_valid_d;
      trig_addr_q   <= trig_addr_d;
      mode_q        <= mode_d;
      triggered_q   <= triggered_d;
      auto_fired_q  <= auto_fired_d;
      frame_ready_q <= frame_ready_d;
      frame_valid_q <= frame_valid_d;
      rd_data_q     <= mem_q[rd_ch_sel][rd_addr];
    end
  end

  // Sample memories; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (we) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem_q[c][wr_ptr_q] <= ch_data_i[c*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data_o     = rd_data_q;
  assign triggered_o   = triggered_q;
  assign auto_fired_o  = auto_fired_q;
  assign frame_ready_o = frame_ready_q;
  assign frame_valid_o = frame_valid_q;

endmodule

// File: tb/tb_capture_buffer_n.sv
// Scoreboard bench for capture_buffer_n: stimulus pushes expected responses,
// monitors pop and compare when the DUT presents read data, status or a frame.
module tb_capture_buffer_n;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic [23:0] ch_data = '0;
  logic [0:0]  trig_ch = '0;
  logic [11:0] trig_level = '0;
  logic        trig_falling = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        arm = 1'b0;
  logic        hold = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  rd_x = '0;
  logic [0:0]  rd_ch = '0;
  logic [11:0] rd_data;
  logic        triggered, auto_fired, frame_ready, frame_valid;

  capture_buffer_n #(
    .NUM_CH(2), .DATA_W(12), .ADDR_W(4), .PRETRIG(4), .AUTO_TIMEOUT(8)
  ) dut (
    .clock_i(clock), .reset_i(reset), .sample_en_i(sample_en), .ch_data_i(ch_data),
    .trig_ch_i(trig_ch), .trig_level_i(trig_level), .trig_falling_i(trig_falling),
    .mode_i(mode), .arm_i(arm), .hold_i(hold), .frame_tick_i(frame_tick),
    .rd_x_i(rd_x), .rd_ch_i(rd_ch), .rd_data_o(rd_data), .triggered_o(triggered),
    .auto_fired_o(auto_fired), .frame_ready_o(frame_ready), .frame_valid_o(frame_valid)
  );

  always #5 clock = ~clock;

  // kind: 0 = rd_data only, 1 = status flags only, 2 = everything
  typedef struct {
    int          kind;
    logic [11:0] data;
    logic        trg, af, fv, fr;
  } exp_t;
  typedef struct {
    int   cnt;
    logic af;
  } frm_t;

  exp_t  exp_q[$];
  string name_q[$];
  frm_t  frm_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_samples = 0;
  logic  chk_req = 1'b0;
  logic  chk_d = 1'b0;
  logic  fr_prev = 1'b0;

  // Requests are registered alongside rd_data, so compare one edge later.
  initial forever begin
    @(posedge clock);
    chk_d = chk_req;
  end

  initial forever begin
    @(negedge clock);
    if (chk_d) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got a check request, want a queued entry");
      end else begin
        exp_t  e;
        string nm;
        logic  ok;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        ok = 1'b1;
        if (e.kind != 1 && rd_data !== e.data) ok = 1'b0;
        if (e.kind != 0 && {triggered, auto_fired, frame_valid, frame_ready} !==
            {e.trg, e.af, e.fv, e.fr}) ok = 1'b0;
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got rd_data=%0d trg=%b af=%b fv=%b fr=%b, want rd_data=%0d trg=%b af=%b fv=%b fr=%b (kind %0d)",
                   nm, rd_data, triggered, auto_fired, frame_valid, frame_ready,
                   e.data, e.trg, e.af, e.fv, e.fr, e.kind);
        end
      end
    end
    if (frame_ready) begin
      n_tests++;
      if (fr_prev) begin
        n_fail++;
        $display("FAIL frame_ready_width: got high for 2+ cycles, want 1-cycle pulse");
      end else if (frm_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame: got frame_ready at sample %0d, want none", n_samples);
      end else begin
        frm_t f;
        f = frm_q.pop_front();
        if (n_samples != f.cnt || frame_valid !== 1'b1 || auto_fired !== f.af) begin
          n_fail++;
          $display("FAIL frame_event: got samples=%0d fv=%b af=%b, want samples=%0d fv=1 af=%b",
                   n_samples, frame_valid, auto_fired, f.cnt, f.af);
        end
      end
    end
    fr_prev = frame_ready;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_sample(input logic [11:0] c0, input logic [11:0] c1);
    sample_en = 1'b1;
    ch_data   = {c1, c0};
    n_samples++;
    tick();
    sample_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic push_chk(input int kind, input logic [11:0] d, input logic trg,
                          input logic af, input logic fv, input logic fr, input string nm);
    exp_t e;
    e.kind = kind; e.data = d; e.trg = trg; e.af = af; e.fv = fv; e.fr = fr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic expect_rd(input int x, input int ch, input logic [11:0] v, input string nm);
    rd_x  = 4'(x);
    rd_ch = 1'(ch);
    push_chk(0, v, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic expect_flags(input logic trg, input logic af, input logic fv, input string nm);
    push_chk(1, 12'd0, trg, af, fv, 1'b0, nm);
  endtask

  task automatic expect_frame(input int cnt, input logic af);
    frm_t f;
    f.cnt = cnt; f.af = af;
    frm_q.push_back(f);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic start(input logic [1:0] m, input int ch, input int lvl, input logic fall);
    mode = m; trig_ch = 1'(ch); trig_level = 12'(lvl); trig_falling = fall;
    hold = 1'b0;
    reset = 1'b1;
    tick();
    push_chk(2, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_outputs");
    reset = 1'b0;
    n_samples = 0;
    tick();
    tick();
  endtask

  task automatic drain(input string nm);
    repeat (4) tick();
    n_tests++;
    if (exp_q.size() != 0 || frm_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d checks and %0d frames pending, want 0 and 0",
               nm, exp_q.size(), frm_q.size());
      exp_q.delete(); name_q.delete(); frm_q.delete();
    end
  endtask

  // Ramp 0,10,20.. on ch0 with level 100: trigger on sample index 10.
  task automatic ramp_capture(input string tag);
    expect_frame(22, 1'b0);
    for (int i = 0; i < 22; i++) begin
      do_sample(12'(10 * i), 12'(1000 + i));
      if (i == 9) expect_flags(1'b0, 1'b0, 1'b0, {tag, "_pre_trigger"});
      if (i == 10) expect_flags(1'b1, 1'b0, 1'b0, {tag, "_trigger"});
    end
    expect_flags(1'b1, 1'b0, 1'b1, {tag, "_done"});
    expect_rd(0, 0, 12'd60, {tag, "_rd_x0"});
    expect_rd(4, 0, 12'd100, {tag, "_rd_x4"});
    expect_rd(15, 0, 12'd210, {tag, "_rd_x15"});
    expect_rd(4, 1, 12'd1010, {tag, "_rd_ch1_x4"});
  endtask

  function automatic logic [11:0] fall1(input int i);
    int v;
    v = 300 - 20 * i;
    return v[11:0];
  endfunction

  initial begin
    // 1: normal mode, rising edge
    start(2'b00, 0, 100, 1'b0);
    ramp_capture("normal");
    pulse_tick();
    expect_flags(1'b0, 1'b0, 1'b0, "normal_release");
    drain("normal");

    // 2: falling edge on ch1, level 200, trigger on 180 (index 6)
    start(2'b00, 1, 200, 1'b1);
    expect_frame(18, 1'b0);
    for (int i = 0; i < 18; i++) begin
      do_sample(12'(7 * i + 3), fall1(i));
      if (i == 5) expect_flags(1'b0, 1'b0, 1'b0, "falling_at_200");
      if (i == 6) expect_flags(1'b1, 1'b0, 1'b0, "falling_trigger");
    end
    expect_rd(4, 1, 12'd180, "falling_rd_x4_ch1");
    expect_rd(0, 1, 12'd260, "falling_rd_x0_ch1");
    expect_rd(15, 1, fall1(17), "falling_rd_x15_ch1");
    expect_rd(0, 0, 12'd17, "falling_rd_x0_ch0");
    expect_rd(5, 0, 12'd52, "falling_rd_x5_ch0");
    expect_rd(15, 0, 12'd122, "falling_rd_x15_ch0");
    drain("falling");

    // 3: auto mode, constant input never crosses the level
    start(2'b01, 0, 100, 1'b0);
    expect_frame(23, 1'b1);
    for (int i = 0; i < 23; i++) begin
      do_sample(12'd5, 12'd5);
      if (i == 10) expect_flags(1'b0, 1'b0, 1'b0, "auto_before_timeout");
      if (i == 11) expect_flags(1'b1, 1'b1, 1'b0, "auto_fired");
    end
    expect_flags(1'b1, 1'b1, 1'b1, "auto_done");
    for (int x = 0; x < 16; x++) expect_rd(x, 0, 12'd5, "auto_rd_ch0");
    expect_rd(9, 1, 12'd5, "auto_rd_ch1");
    drain("auto");

    // 4: single mode
    start(2'b10, 0, 100, 1'b0);
    for (int i = 0; i < 3; i++) do_sample(12'(500 + i), 12'd0);
    pulse_arm();
    n_samples = 0;
    ramp_capture("single");
    pulse_tick();
    for (int i = 0; i < 20; i++) do_sample(12'(10 * i), 12'd0);
    pulse_tick();
    expect_flags(1'b1, 1'b0, 1'b1, "single_no_restart");
    hold = 1'b1;
    pulse_arm();
    expect_flags(1'b1, 1'b0, 1'b1, "single_hold_blocks_arm");
    hold = 1'b0;
    tick();
    pulse_arm();
    expect_flags(1'b0, 1'b0, 1'b0, "single_rearm");
    n_samples = 0;
    ramp_capture("single2");
    drain("single");

    // 5: wrap-around, trigger on index 13
    start(2'b00, 0, 500, 1'b0);
    expect_frame(25, 1'b0);
    for (int i = 0; i < 25; i++) begin
      do_sample((i < 13) ? 12'(5 * i + 1) : 12'(1000 + i), 12'(2000 + i));
      if (i == 12) expect_flags(1'b0, 1'b0, 1'b0, "wrap_pre_trigger");
      if (i == 13) expect_flags(1'b1, 1'b0, 1'b0, "wrap_trigger");
    end
    expect_rd(0, 0, 12'd46, "wrap_rd_x0");
    expect_rd(7, 0, 12'd1016, "wrap_rd_x7");
    expect_rd(15, 0, 12'd1024, "wrap_rd_x15");
    expect_rd(0, 1, 12'd2009, "wrap_rd_x0_ch1");
    expect_rd(15, 1, 12'd2024, "wrap_rd_x15_ch1");
    drain("wrap");

    // 6: reset asserted in POST, then a fresh capture
    start(2'b00, 0, 100, 1'b0);
    for (int i = 0; i < 14; i++) do_sample(12'(10 * i), 12'(1000 + i));
    rd_x = 4'd4;
    expect_flags(1'b1, 1'b0, 1'b0, "post_before_reset");
    reset = 1'b1;
    push_chk(2, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_in_post");
    reset = 1'b0;
    tick();
    n_samples = 0;
    ramp_capture("after_reset");
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
